// File: rtl/spi_mc_pkg.sv
// rtl/spi_mc_pkg.sv - shared register map, CTRL layout and FSM states for spi_master_mc
package spi_mc_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int CTRL_DIV_LSB   = 0;
    localparam int CTRL_LEN_LSB   = 16;
    localparam int CTRL_CS_LSB    = 22;
    localparam int CTRL_CPOL_BIT  = 25;
    localparam int CTRL_CPHA_BIT  = 26;
    localparam int CTRL_IRQEN_BIT = 27;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_OVERRUN_BIT = 2;

    // Field order mirrors the CTRL bit positions above, MSB first.
    typedef struct packed {
        logic [3:0]  rsvd;
        logic        irq_en;
        logic        cpha;
        logic        cpol;
        logic [2:0]  cs_idx;
        logic [5:0]  len;
        logic [15:0] div;
    } ctrl_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    // LEN of zero or beyond the shifter width selects the full shifter width.
    function automatic logic [5:0] eff_len(input logic [5:0] len, input logic [5:0] max_len);
        return (len == 6'd0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - half-period timer producing tick and leading/trailing SCLK edge strobes
module spi_clkgen (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        shifting,
    input  logic [15:0] div,
    output logic        tick,
    output logic        lead,
    output logic        trail
);

    logic [15:0] cnt;
    logic        phase;

    // A tick marks the end of each half period of DIV+1 clocks.
    assign tick  = run && (cnt == div);
    assign lead  = tick && shifting && !phase;
    assign trail = tick && shifting && phase;

    // Half-period counter restarts on every tick and whenever the timer is idle.
    always_ff @(posedge clk) begin
        if (reset || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Edge phase alternates leading/trailing only while SCLK is actually toggling.
    always_ff @(posedge clk) begin
        if (reset || !shifting) begin
            phase <= 1'b0;
        end else if (tick) begin
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - bus-mapped multi-channel SPI master with selectable mode, length and divider
module spi_master_mc
    import spi_mc_pkg::*;
#(
    parameter int AddrWidth  = 15,
    parameter int BusWidth   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [AddrWidth-1:0] address,
    input  logic [BusWidth-1:0]  busdatain,
    output logic [BusWidth-1:0]  busdataout,
    input  logic                 write,
    input  logic                 read,
    output logic                 irq,
    output logic [NUM_CS-1:0]    spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam logic [5:0] MaxLen = 6'(DATA_WIDTH);

    ctrl_t                 ctrl;
    state_t                state;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] rx;
    logic [5:0]            len_l;
    logic [5:0]            len_e;
    logic [5:0]            bit_cnt;
    logic [2:0]            cs_l;
    logic                  cpha_l;
    logic [15:0]           div_l;
    logic                  done;
    logic                  overrun;
    logic                  samp;
    logic                  tick;
    logic                  lead;
    logic                  trail;
    logic                  wr;
    logic                  rd;
    logic                  busy;
    logic                  start;
    logic                  last_trail;
    logic                  cs_active;
    logic                  run;
    logic [1:0]            reg_addr;
    logic [BusWidth-1:0]   rd_val;
    logic                  unused_bus;

    assign unused_bus = ^{address, busdatain};

    assign reg_addr   = address[1:0];
    assign wr         = sel & write;
    assign rd         = sel & read;
    assign busy       = (state != IDLE);
    assign start      = wr && (reg_addr == REG_DATA) && !busy;
    assign len_e      = eff_len(ctrl.len, MaxLen);
    assign last_trail = trail && (bit_cnt == len_l - 6'd1);
    assign cs_active  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign run        = cs_active;
    assign irq        = done & ctrl.irq_en;

    spi_clkgen u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .shifting (state == SHIFT),
        .div      (div_l),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: each phase lasts whole half periods, DONE lasts one clock.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start)      state_d = SETUP;
            SETUP:   if (tick)       state_d = SHIFT;
            SHIFT:   if (last_trail) state_d = HOLD;
            HOLD:    if (tick)       state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Chip selects: only the latched index is driven low, and only while framing a transfer.
    always_comb begin
        spi_cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_active && (cs_l == i[2:0])) begin
                spi_cs_n[i] = 1'b0;
            end
        end
    end

    // CTRL register; writes while busy are dropped so a transfer in flight never changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
        end else if (wr && (reg_addr == REG_CTRL) && !busy) begin
            ctrl <= ctrl_t'({4'b0000, busdatain[27:0]});
        end
    end

    // Status flags; a start beats a done-clear, and a completing transfer beats a done-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr && (reg_addr == REG_STATUS)) begin
                if (busdatain[STAT_DONE_BIT]) begin
                    done <= 1'b0;
                end
                if (busdatain[STAT_OVERRUN_BIT]) begin
                    overrun <= 1'b0;
                end
            end
            if (wr && busy && ((reg_addr == REG_CTRL) || (reg_addr == REG_DATA))) begin
                overrun <= 1'b1;
            end
            if (start) begin
                done <= 1'b0;
            end
            if (state == DONE) begin
                done <= 1'b1;
            end
        end
    end

    // Shift datapath: tx is left-aligned so the MSB of the active word is always sh[top],
    // and received bits enter at the bottom so rx ends up right-aligned and zero-extended.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh       <= '0;
            rx       <= '0;
            len_l    <= '0;
            cs_l     <= '0;
            cpha_l   <= 1'b0;
            div_l    <= '0;
            bit_cnt  <= '0;
            samp     <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            if (start) begin
                sh      <= busdatain[DATA_WIDTH-1:0] << (MaxLen - len_e);
                len_l   <= len_e;
                cs_l    <= ctrl.cs_idx;
                cpha_l  <= ctrl.cpha;
                div_l   <= ctrl.div;
                bit_cnt <= '0;
            end
            if ((state == SETUP) && !cpha_l) begin
                spi_mosi <= sh[DATA_WIDTH-1];
            end
            if (lead) begin
                if (cpha_l) begin
                    spi_mosi <= sh[DATA_WIDTH-1];
                end else begin
                    samp <= spi_miso;
                end
            end
            if (trail) begin
                bit_cnt <= bit_cnt + 6'd1;
                sh      <= {sh[DATA_WIDTH-2:0], cpha_l ? spi_miso : samp};
                if (!cpha_l && !last_trail) begin
                    spi_mosi <= sh[DATA_WIDTH-2];
                end
            end
            if (state == DONE) begin
                rx <= sh;
            end
        end
    end

    // SCLK toggles on every half-period tick in SHIFT and rests at CPOL otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_sclk <= 1'b0;
        end else if (state == SHIFT) begin
            if (tick) begin
                spi_sclk <= ~spi_sclk;
            end
        end else begin
            spi_sclk <= ctrl.cpol;
        end
    end

    // Read mux for the register map; unused bits read as zero.
    always_comb begin
        rd_val = '0;
        case (reg_addr)
            REG_CTRL:   rd_val[31:0]           = ctrl;
            REG_DATA:   rd_val[DATA_WIDTH-1:0] = rx;
            REG_STATUS: rd_val[2:0]            = {overrun, done, busy};
            default:    rd_val                 = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            busdataout <= '0;
        end else if (rd) begin
            busdataout <= rd_val;
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - self-checking bench for spi_master_mc against an SPI slave reference model
module tb_spi_master_mc;

    localparam int AW  = 15;
    localparam int BW  = 32;
    localparam int DW  = 32;
    localparam int NCS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [AW-1:0] address = '0;
    logic [BW-1:0] busdatain = '0;
    logic [BW-1:0] busdataout;
    logic          irq;
    logic [NCS-1:0] spi_cs_n;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso;

    int checks = 0;
    int passed = 0;

    // Slave/monitor state
    bit            slave_loop = 1'b0;
    logic [31:0]   slave_word = '0;
    int            slave_len = 32;
    bit            mon_cpha = 1'b0;
    int            edges = 0;
    int            ptr = 0;
    int            since = 0;
    int            gmin = 1000;
    int            gmax = 0;
    logic [31:0]   mosi_cap = '0;
    logic [NCS-1:0] cs_seen = '0;
    logic          prev_sclk = 1'b0;

    spi_master_mc #(
        .AddrWidth  (AW),
        .BusWidth   (BW),
        .DATA_WIDTH (DW),
        .NUM_CS     (NCS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .address    (address),
        .busdatain  (busdatain),
        .busdataout (busdataout),
        .write      (write),
        .read       (read),
        .irq        (irq),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    // SPI slave view: count SCLK edges, capture MOSI on sample edges, time half periods.
    always @(negedge clk) begin
        since++;
        cs_seen = cs_seen | ~spi_cs_n;
        if (spi_sclk !== prev_sclk) begin
            edges++;
            if (edges > 1) begin
                if (since < gmin) gmin = since;
                if (since > gmax) gmax = since;
            end
            since = 0;
            if (mon_cpha ? (edges % 2 == 0) : (edges % 2 == 1)) begin
                mosi_cap = {mosi_cap[30:0], spi_mosi};
                ptr++;
            end
        end
        prev_sclk = spi_sclk;
    end

    // Slave drives its word MSB first, advancing after each sample edge.
    always_comb begin
        if (slave_loop) spi_miso = spi_mosi;
        else if (ptr < slave_len) spi_miso = slave_word[slave_len-1-ptr];
        else spi_miso = 1'b0;
    end

    function automatic int ref_len(input logic [5:0] l);
        return (l == 6'd0 || int'(l) > DW) ? DW : int'(l);
    endfunction

    function automatic logic [31:0] ref_mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] mk_ctrl(input int dv, input int ln, input int cs,
                                            input int cpol, input int cpha, input int ien);
        logic [31:0] c;
        c = '0;
        c[15:0]  = dv[15:0];
        c[21:16] = ln[5:0];
        c[24:22] = cs[2:0];
        c[25]    = cpol[0];
        c[26]    = cpha[0];
        c[27]    = ien[0];
        return c;
    endfunction

    function automatic logic [NCS-1:0] ref_cs(input int cs);
        logic [NCS-1:0] m;
        m = '0;
        if (cs < NCS) m[cs] = 1'b1;
        return m;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; write = 1'b1; address = AW'(a); busdatain = d;
        @(posedge clk); #1;
        sel = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; read = 1'b1; address = AW'(a);
        @(posedge clk); #1;
        sel = 1'b0; read = 1'b0;
        d = busdataout;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_read(2'd2, s);
            if (s[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic mon_clear();
        edges = 0; ptr = 0; since = 0; gmin = 1000; gmax = 0;
        mosi_cap = '0; cs_seen = '0; prev_sclk = spi_sclk;
    endtask

    task automatic start_xfer(input logic [31:0] cv, input logic [31:0] tx,
                              input logic [31:0] sw, input bit loop);
        bus_write(2'd0, cv);
        @(posedge clk); #1;
        mon_cpha = cv[26]; slave_loop = loop; slave_word = sw; slave_len = ref_len(cv[21:16]);
        mon_clear();
        bus_write(2'd1, tx);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++; if (spi_cs_n !== 4'hF) $display("FAIL reset_cs_n got %h want f", spi_cs_n); else passed++;
        checks++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", spi_sclk); else passed++;
        checks++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", spi_mosi); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
        checks++; if (busdataout !== 32'h0) $display("FAIL reset_busdataout got %h want 0", busdataout); else passed++;
        bus_read(2'd0, r);
        checks++; if (r !== 32'h0) $display("FAIL reset_ctrl got %h want 0", r); else passed++;
        bus_read(2'd2, r);
        checks++; if (r !== 32'h0) $display("FAIL reset_status got %h want 0", r); else passed++;
        bus_read(2'd1, r);
        checks++; if (r !== 32'h0) $display("FAIL reset_data got %h want 0", r); else passed++;
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, r);
        checks++; if (r !== 32'h0) $display("FAIL reg3_read got %h want 0", r); else passed++;
    endtask

    task automatic test_mode0();
        logic [31:0] r;
        bit ok;
        start_xfer(mk_ctrl(1, 8, 2, 0, 0, 1), 32'h0000_00A5, 32'h0000_003C, 1'b0);
        wait_idle(2000, ok);
        checks++; if (!ok) $display("FAIL mode0_timeout got busy want idle"); else passed++;
        checks++; if (mosi_cap[7:0] !== 8'hA5) $display("FAIL mode0_mosi got %h want a5", mosi_cap[7:0]); else passed++;
        checks++; if (edges !== 16) $display("FAIL mode0_edges got %0d want 16", edges); else passed++;
        checks++; if (gmin !== 2 || gmax !== 2) $display("FAIL mode0_halfper got %0d..%0d want 2", gmin, gmax); else passed++;
        checks++; if (cs_seen !== 4'b0100) $display("FAIL mode0_cs got %b want 0100", cs_seen); else passed++;
        bus_read(2'd2, r);
        checks++; if (r !== 32'h2) $display("FAIL mode0_status got %h want 2", r); else passed++;
        bus_read(2'd1, r);
        checks++; if (r !== 32'h3C) $display("FAIL mode0_rx got %h want 3c", r); else passed++;
        checks++; if (irq !== 1'b1) $display("FAIL mode0_irq got %b want 1", irq); else passed++;
        bus_write(2'd2, 32'h2);
        checks++; if (irq !== 1'b0) $display("FAIL mode0_irq_clear got %b want 0", irq); else passed++;
    endtask

    task automatic test_modes_loopback();
        logic [31:0] r;
        bit ok;
        for (int m = 1; m < 4; m++) begin
            bus_write(2'd0, mk_ctrl(0, 0, 0, m >> 1, m & 1, 0));
            @(posedge clk); #1;
            checks++; if (spi_sclk !== 1'(m >> 1)) $display("FAIL mode%0d_idle_pre got %b want %0d", m, spi_sclk, m >> 1); else passed++;
            start_xfer(mk_ctrl(0, 0, 0, m >> 1, m & 1, 0), 32'hDEAD_BEEF, 32'h0, 1'b1);
            wait_idle(2000, ok);
            checks++; if (!ok) $display("FAIL mode%0d_timeout got busy want idle", m); else passed++;
            bus_read(2'd1, r);
            checks++; if (r !== 32'hDEAD_BEEF) $display("FAIL mode%0d_rx got %h want deadbeef", m, r); else passed++;
            checks++; if (edges !== 64) $display("FAIL mode%0d_edges got %0d want 64", m, edges); else passed++;
            checks++; if (spi_sclk !== 1'(m >> 1)) $display("FAIL mode%0d_idle got %b want %0d", m, spi_sclk, m >> 1); else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] r, cv, tx, sw;
        int dv, ln, cs, cpol, cpha, ien, n;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            dv = $urandom_range(0, 3); ln = $urandom_range(0, 40); cs = $urandom_range(0, 7);
            cpol = $urandom_range(0, 1); cpha = $urandom_range(0, 1); ien = $urandom_range(0, 1);
            tx = $urandom; sw = $urandom;
            cv = mk_ctrl(dv, ln, cs, cpol, cpha, ien);
            n = ref_len(cv[21:16]);
            start_xfer(cv, tx, sw, 1'b0);
            wait_idle(2000, ok);
            checks++; if (!ok) $display("FAIL rnd%0d_timeout got busy want idle", k); else passed++;
            checks++; if ((mosi_cap & ref_mask(n)) !== (tx & ref_mask(n))) $display("FAIL rnd%0d_mosi got %h want %h", k, mosi_cap & ref_mask(n), tx & ref_mask(n)); else passed++;
            checks++; if (edges !== 2 * n) $display("FAIL rnd%0d_edges got %0d want %0d", k, edges, 2 * n); else passed++;
            checks++; if (gmin !== dv + 1 || gmax !== dv + 1) $display("FAIL rnd%0d_halfper got %0d..%0d want %0d", k, gmin, gmax, dv + 1); else passed++;
            checks++; if (cs_seen !== ref_cs(cs)) $display("FAIL rnd%0d_cs got %b want %b", k, cs_seen, ref_cs(cs)); else passed++;
            bus_read(2'd1, r);
            checks++; if (r !== (sw & ref_mask(n))) $display("FAIL rnd%0d_rx got %h want %h", k, r, sw & ref_mask(n)); else passed++;
            checks++; if (irq !== 1'(ien)) $display("FAIL rnd%0d_irq got %b want %0d", k, irq, ien); else passed++;
            checks++; if (spi_sclk !== 1'(cpol)) $display("FAIL rnd%0d_idle got %b want %0d", k, spi_sclk, cpol); else passed++;
        end
    endtask

    task automatic test_cs_out_of_range();
        logic [31:0] r;
        bit ok;
        start_xfer(mk_ctrl(1, 4, 5, 0, 0, 0), 32'h0000_0009, 32'h0000_0006, 1'b0);
        wait_idle(2000, ok);
        checks++; if (!ok) $display("FAIL cs5_timeout got busy want idle"); else passed++;
        checks++; if (edges !== 8) $display("FAIL cs5_edges got %0d want 8", edges); else passed++;
        checks++; if (cs_seen !== 4'b0000) $display("FAIL cs5_cs got %b want 0000", cs_seen); else passed++;
        checks++; if (mosi_cap[3:0] !== 4'h9) $display("FAIL cs5_mosi got %h want 9", mosi_cap[3:0]); else passed++;
        bus_read(2'd2, r);
        checks++; if (r !== 32'h2) $display("FAIL cs5_status got %h want 2", r); else passed++;
        bus_read(2'd1, r);
        checks++; if (r !== 32'h6) $display("FAIL cs5_rx got %h want 6", r); else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] r, tx, cv;
        bit ok;
        tx = $urandom;
        cv = mk_ctrl(3, 0, 0, 0, 0, 0);
        start_xfer(cv, tx, 32'h0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        bus_write(2'd1, 32'h0000_1234);
        bus_write(2'd0, 32'h0FFF_FFFF);
        bus_read(2'd2, r);
        checks++; if (r !== 32'h5) $display("FAIL ovr_status_busy got %h want 5", r); else passed++;
        wait_idle(2000, ok);
        checks++; if (!ok) $display("FAIL ovr_timeout got busy want idle"); else passed++;
        bus_read(2'd1, r);
        checks++; if (r !== tx) $display("FAIL ovr_rx got %h want %h", r, tx); else passed++;
        checks++; if (mosi_cap !== tx) $display("FAIL ovr_mosi got %h want %h", mosi_cap, tx); else passed++;
        bus_read(2'd0, r);
        checks++; if (r !== cv) $display("FAIL ovr_ctrl got %h want %h", r, cv); else passed++;
        bus_read(2'd2, r);
        checks++; if (r !== 32'h6) $display("FAIL ovr_status_done got %h want 6", r); else passed++;
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, r);
        checks++; if (r !== 32'h2) $display("FAIL ovr_clear got %h want 2", r); else passed++;
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, r);
        checks++; if (r !== 32'h0) $display("FAIL done_clear got %h want 0", r); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, t1, t2;
        bit ok;
        t1 = $urandom; t2 = $urandom;
        start_xfer(mk_ctrl(0, 8, 3, 0, 0, 0), t1, 32'h0, 1'b1);
        wait_idle(2000, ok);
        checks++; if (!ok) $display("FAIL b2b_first_timeout got busy want idle"); else passed++;
        mon_clear();
        bus_write(2'd1, t2);
        bus_read(2'd2, r);
        checks++; if (r !== 32'h1) $display("FAIL b2b_status_start got %h want 1", r); else passed++;
        wait_idle(2000, ok);
        checks++; if (!ok) $display("FAIL b2b_second_timeout got busy want idle"); else passed++;
        bus_read(2'd1, r);
        checks++; if (r !== {24'h0, t2[7:0]}) $display("FAIL b2b_rx got %h want %h", r, {24'h0, t2[7:0]}); else passed++;
        checks++; if (mosi_cap[7:0] !== t2[7:0]) $display("FAIL b2b_mosi got %h want %h", mosi_cap[7:0], t2[7:0]); else passed++;
        checks++; if (cs_seen !== 4'b1000) $display("FAIL b2b_cs got %b want 1000", cs_seen); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bit reached;
        start_xfer(mk_ctrl(2, 16, 1, 0, 0, 1), $urandom, 32'h0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (edges >= 5) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (!reached) $display("FAIL rstmid_reach got %0d edges want 5", edges); else passed++;
        checks++; if (spi_cs_n !== 4'b1101) $display("FAIL rstmid_cs_before got %b want 1101", spi_cs_n); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (spi_cs_n !== 4'hF) $display("FAIL rstmid_cs got %h want f", spi_cs_n); else passed++;
        checks++; if (spi_sclk !== 1'b0) $display("FAIL rstmid_sclk got %b want 0", spi_sclk); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL rstmid_irq got %b want 0", irq); else passed++;
        bus_read(2'd2, r);
        checks++; if (r !== 32'h0) $display("FAIL rstmid_status got %h want 0", r); else passed++;
        bus_read(2'd1, r);
        checks++; if (r !== 32'h0) $display("FAIL rstmid_rx got %h want 0", r); else passed++;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (irq !== 1'b0) $display("FAIL rstmid_irq_late got %b want 0", irq); else passed++;
        bus_read(2'd2, r);
        checks++; if (r !== 32'h0) $display("FAIL rstmid_status_late got %h want 0", r); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_mode0();
        test_modes_loopback();
        test_random();
        test_cs_out_of_range();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
